// File: rtl/sram_fifo_pkg.sv
// Shared types and helpers for the SRAM-backed stream FIFO.
package sram_fifo_pkg;

  // Occupancy of the show-ahead prefetch buffer; the encoding equals the slot count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slot_state_e;

  // Width needed to hold a count from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Next pointer value, wrapping depth-1 -> 0 for any depth (no power-of-two masking).
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Two-entry show-ahead buffer in front of the SRAM. Slot 0 is the head seen by
// the consumer. Words arrive either by bypass (straight from the producer) or
// from an SRAM read issued the previous cycle; the two never coincide.
//
//   state | meaning
//   EMPTY | no valid slot, head invalid
//   ONE   | slot 0 valid
//   TWO   | slots 0 and 1 valid
module fifo_prefetch_buf
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             byp_valid_i,
  input  logic [WIDTH-1:0] byp_data_i,
  input  logic             rd_issue_i,
  input  logic [WIDTH-1:0] ret_data_i,
  input  logic             pop_i,
  output logic             in_flight_o,
  output logic [1:0]       slots_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic             in_flight_q;
  logic             land;
  logic [WIDTH-1:0] land_data;

  // SRAM data is valid exactly one cycle after the read was issued.
  assign land      = byp_valid_i | in_flight_q;
  assign land_data = in_flight_q ? ret_data_i : byp_data_i;

  // State, slot storage and in-flight marker.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      slot0_q     <= '0;
      slot1_q     <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      in_flight_q <= rd_issue_i;
    end
  end

  // Arriving words fill the first free slot after any pop has shifted slot 1 forward.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      EMPTY: begin
        if (land) begin
          slot0_d = land_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (pop_i && land) begin
          slot0_d = land_data;
        end else if (pop_i) begin
          state_d = EMPTY;
        end else if (land) begin
          slot1_d = land_data;
          state_d = TWO;
        end
      end
      TWO: begin
        if (pop_i) begin
          slot0_d = slot1_q;
          if (land) slot1_d = land_data;
          else      state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign slots_o     = state_q;
  assign in_flight_o = in_flight_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = slot0_q;

endmodule

// File: rtl/sram_dualport.sv
// Behavioural model of the existing sram_dualport macro: one write port, one
// read port, read data registered one cycle after re_i. Contents are not reset.
module sram_dualport #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write and registered read.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/sram_fifo_stream.sv
// SRAM-backed valid/ready FIFO with a two-entry show-ahead prefetch buffer.
// Optional build macro SRAM_FIFO_STREAM_ERR_EN enables the sticky err_o checker;
// without it err_o is tied low.
module sram_fifo_stream
  import sram_fifo_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  localparam int CW        = cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CW-1:0]    count_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             err_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q, sram_cnt_q;
  logic             push, pop, byp, sram_wr, rd_issue, in_flight;
  logic [1:0]       slots;
  logic [2:0]       occ;
  logic [WIDTH-1:0] rd_data;

  assign in_ready_o = (cnt_q != CW'(DEPTH));
  assign push       = in_valid_i & in_ready_o;
  assign pop        = out_valid_o & out_ready_i;

  // Bypass only when nothing older sits in or is leaving the SRAM, so order holds.
  assign byp     = push & (sram_cnt_q == '0) & ~in_flight & ((slots != 2'd2) | pop);
  assign sram_wr = push & ~byp;

  // A read may be issued if the slot it lands in will be free; counting the
  // same-cycle pop keeps back-to-back pops bubble-free.
  assign occ      = {1'b0, slots} + {2'b00, in_flight};
  assign rd_issue = (sram_cnt_q != '0) & ((occ < 3'd2) | ((occ == 3'd2) & pop));

  // Pointers and occupancy counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (sram_wr)  wr_ptr_q <= PW'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
      if (rd_issue) rd_ptr_q <= PW'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));
      case ({sram_wr, rd_issue})
        2'b10:   sram_cnt_q <= sram_cnt_q + CW'(1);
        2'b01:   sram_cnt_q <= sram_cnt_q - CW'(1);
        default: sram_cnt_q <= sram_cnt_q;
      endcase
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  sram_dualport #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_sram (
    .clk_i   (clk_i),
    .we_i    (sram_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data_i),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  fifo_prefetch_buf #(
    .WIDTH (WIDTH)
  ) u_prefetch (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byp_valid_i (byp),
    .byp_data_i  (in_data_i),
    .rd_issue_i  (rd_issue),
    .ret_data_i  (rd_data),
    .pop_i       (pop),
    .in_flight_o (in_flight),
    .slots_o     (slots),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o)
  );

  assign count_o        = cnt_q;
  assign almost_full_o  = (int'(cnt_q) >= AF_THRESH);
  assign almost_empty_o = (int'(cnt_q) <= AE_THRESH);

`ifdef SRAM_FIFO_STREAM_ERR_EN
  logic             stall_q;
  logic [WIDTH-1:0] stall_data_q;
  logic             err_q;

  // Remember stalled offers and latch any protocol or bookkeeping breach.
  // A word in flight from SRAM is counted with the slots it is about to enter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      stall_q      <= in_valid_i & ~in_ready_o;
      stall_data_q <= in_data_i;
      if ((stall_q & (~in_valid_i | (in_data_i != stall_data_q))) ||
          ((sram_cnt_q + CW'(slots) + CW'(in_flight)) != cnt_q))
        err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_stream.sv
// Scoreboard bench for sram_fifo_stream: a DEPTH=16 and a DEPTH=5 instance
// driven with directed sequences; a negedge monitor keeps a reference count and
// an expected-data queue per instance and checks every popped head word.
module tb_sram_fifo_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_valid, out_ready;
  logic [7:0] in_data [2];
  wire  [1:0] in_ready, out_valid, af, ae, err;
  wire  [7:0] od16, od5;
  wire  [4:0] cnt16;
  wire  [2:0] cnt5;

  int checks   = 0;
  int failures = 0;

  int         mcnt [2];
  logic [7:0] q [2][$];

  always #5 clk = ~clk;

  sram_fifo_stream #(.WIDTH(8), .DEPTH(16)) u_d16 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(od16),
    .count_o(cnt16), .almost_full_o(af[0]), .almost_empty_o(ae[0]), .err_o(err[0])
  );

  sram_fifo_stream #(.WIDTH(8), .DEPTH(5)) u_d5 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(od5),
    .count_o(cnt5), .almost_full_o(af[1]), .almost_empty_o(ae[1]), .err_o(err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int i);
    chk($sformatf("rst_valid%0d", i), 32'(out_valid[i]), 32'd0);
    chk($sformatf("rst_data%0d", i), (i == 0) ? 32'(od16) : 32'(od5), 32'd0);
    chk($sformatf("rst_count%0d", i), (i == 0) ? 32'(cnt16) : 32'(cnt5), 32'd0);
    chk($sformatf("rst_ready%0d", i), 32'(in_ready[i]), 32'd1);
    chk($sformatf("rst_ae%0d", i), 32'(ae[i]), 32'd1);
    chk($sformatf("rst_af%0d", i), 32'(af[i]), 32'd0);
    chk($sformatf("rst_err%0d", i), 32'(err[i]), 32'd0);
  endtask

  // Reference model and scoreboard: sampled mid-cycle, ahead of the next edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int         d;
      logic [31:0] c;
      logic [7:0]  od;
      logic [7:0]  exp_d;
      bit          mpush, mpop;
      d  = (i == 0) ? 16 : 5;
      c  = (i == 0) ? 32'(cnt16) : 32'(cnt5);
      od = (i == 0) ? od16 : od5;
      if (rst) begin
        mcnt[i] = 0;
        q[i].delete();
      end else begin
        chk($sformatf("count%0d", i), c, 32'(mcnt[i]));
        chk($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(mcnt[i] != d));
        chk($sformatf("out_valid%0d", i), 32'(out_valid[i]), 32'(mcnt[i] != 0));
        chk($sformatf("almost_full%0d", i), 32'(af[i]), 32'(mcnt[i] >= d - 2));
        chk($sformatf("almost_empty%0d", i), 32'(ae[i]), 32'(mcnt[i] <= 2));
        chk($sformatf("err%0d", i), 32'(err[i]), 32'd0);
        mpop  = out_ready[i] && (mcnt[i] != 0);
        mpush = in_valid[i] && (mcnt[i] != d);
        if (mpop) begin
          chk($sformatf("sb_nonempty%0d", i), 32'(q[i].size() != 0), 32'd1);
          if (q[i].size() != 0) begin
            exp_d = q[i].pop_front();
            chk($sformatf("head_data%0d", i), 32'(od), 32'(exp_d));
          end
        end
        if (mpush) q[i].push_back(in_data[i]);
        mcnt[i] = mcnt[i] + int'(mpush) - int'(mpop);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = '0;
    out_ready  = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    #3;
    chk_reset(0);
    chk_reset(1);
    tick();
    tick();
    rst = 1'b0;

    // Single push into empty FIFO shows up at the head next cycle.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hA5;
    tick();
    in_valid[0] = 1'b0;
    chk("a5_valid", 32'(out_valid[0]), 32'd1);
    chk("a5_data", 32'(od16), 32'hA5);
    chk("a5_count", 32'(cnt16), 32'd1);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("a5_drained", 32'(cnt16), 32'd0);

    // Fill DEPTH=16 with 0..15, consumer stalled.
    for (int k = 0; k < 16; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(k);
      tick();
      chk("fill_count", 32'(cnt16), 32'(k + 1));
      chk("fill_af", 32'(af[0]), 32'(k + 1 >= 14));
    end
    chk("full_ready", 32'(in_ready[0]), 32'd0);
    in_data[0] = 8'h10;
    tick();
    tick();
    tick();
    chk("refused_count", 32'(cnt16), 32'd16);
    in_valid[0] = 1'b0;

    // Drain: 0..15 in order, one per cycle.
    out_ready[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("drain_valid", 32'(out_valid[0]), 32'd1);
      chk("drain_data", 32'(od16), 32'(k));
      if (k == 1) chk("ready_back", 32'(in_ready[0]), 32'd1);
    end
    tick();
    out_ready[0] = 1'b0;
    chk("drain_empty_valid", 32'(out_valid[0]), 32'd0);
    chk("drain_empty_count", 32'(cnt16), 32'd0);

    // DEPTH=5 streaming from count 3: output is input delayed by three words.
    in_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data[1] = 8'(8'h10 + k);
      tick();
    end
    out_ready[1] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_data[1] = 8'(8'h13 + c);
      @(negedge clk);
      chk("stream_data", 32'(od5), 32'(8'h10 + c));
      chk("stream_count", 32'(cnt5), 32'd3);
      tick();
    end
    in_valid[1] = 1'b0;
    tick();
    tick();
    tick();
    out_ready[1] = 1'b0;
    chk("stream_drained", 32'(cnt5), 32'd0);

    // Count 1 with simultaneous push and pop.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h77;
    tick();
    in_data[0]   = 8'h3C;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("c1_old_head", 32'(od16), 32'h77);
    tick();
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    chk("c1_new_head", 32'(od16), 32'h3C);
    chk("c1_count", 32'(cnt16), 32'd1);
    chk("c1_valid", 32'(out_valid[0]), 32'd1);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;

    // Asynchronous reset in the middle of a burst at count 7.
    in_valid[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_data[0] = 8'(8'h20 + k);
      tick();
    end
    out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data[0] = 8'(8'h27 + k);
      tick();
      chk("burst_count", 32'(cnt16), 32'd7);
    end
    #1;
    rst = 1'b1;
    #1;
    chk_reset(0);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h5A;
    tick();
    in_valid[0] = 1'b0;
    chk("post_rst_valid", 32'(out_valid[0]), 32'd1);
    chk("post_rst_data", 32'(od16), 32'h5A);
    chk("post_rst_count", 32'(cnt16), 32'd1);
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("post_rst_drained", 32'(cnt16), 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_fifo_stream.md
Name: sram_fifo_stream

Overview:
Next-generation SRAM-backed FIFO with a valid/ready stream interface on both sides. Sustains one push and one pop per cycle, including through empty and full.
- DEPTH may be any integer >= 2, not only a power of two.
- Exposes occupancy count and threshold flags.
- Hides the 1-cycle read latency of the existing sram_dualport macro with a 2-entry output prefetch buffer.
- Sits between producer and consumer pipeline stages wherever a deep, show-ahead buffer is needed.

Parameters:
WIDTH, 8, data width in bits (>= 1)
DEPTH, 16, total capacity in entries (>= 2, any integer)
AF_THRESH, DEPTH-2, almost_full_o asserted when count_o >= AF_THRESH
AE_THRESH, 2, almost_empty_o asserted when count_o <= AE_THRESH

Ports:
clk_i  in  1  clock, all logic on posedge
rst_i  in  1  reset, asynchronous, active-high
in_valid_i  in  1  producer has data
in_ready_o  out  1  FIFO can accept data
in_data_i  in  WIDTH  write data
out_valid_o  out  1  head entry valid (show-ahead)
out_ready_i  in  1  consumer accepts head
out_data_o  out  WIDTH  head entry data
count_o  out  $clog2(DEPTH+1)  entries currently held
almost_full_o  out  1  count_o >= AF_THRESH
almost_empty_o  out  1  count_o <= AE_THRESH
err_o  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Handshakes:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - in_valid_i must be held until accepted; the FIFO never drops accepted data and preserves strict order.
- in_ready_o = (count_o != DEPTH).
  - Driven from registers only; no combinational path from out_ready_i.
  - Push while full is therefore refused even if a pop occurs in the same cycle.
- out_valid_o and out_data_o are registered outputs of prefetch slot 0 (head). Slot 1 holds the next entry.
- Latency:
  - Push into an empty FIFO: out_valid_o = 1 with that data on the next cycle. The data bypasses SRAM into the head slot.
  - Pops at 1 per cycle are sustainable indefinitely while count_o >= 1 and pushes keep pace.
- Routing of each push:
  - The word goes to the first free prefetch slot if SRAM holds no entries and no SRAM read is in flight.
  - Otherwise it is written to SRAM at wr_ptr.
- SRAM read:
  - Issued when SRAM is non-empty and (prefetch slots occupied + reads in flight) < 2.
  - Read data lands in the first free slot one cycle later.
- Pointers:
  - wr_ptr and rd_ptr wrap from DEPTH-1 to 0, with no power-of-two arithmetic.
  - SRAM occupancy is kept as a separate counter.
  - SRAM plus slots never exceed DEPTH.
- count_o:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Updates the cycle after the handshake.
- Boundary cases:
  - count 1, simultaneous push and pop: count stays 1; the new word is at the head next cycle.
  - count DEPTH with pop: in_ready_o returns to 1 next cycle.
  - out_ready_i high while empty: no effect.
- Reset (any cycle, including mid-burst):
  - All pointers, counters and slots clear immediately.
  - Output values: out_valid_o = 0, out_data_o = 0, count_o = 0, in_ready_o = 1, almost_empty_o = 1, almost_full_o = (AF_THRESH == 0), err_o = 0.
  - Data held in SRAM is discarded. SRAM contents themselves are not cleared.

Optional Feature:
SRAM_FIFO_STREAM_ERR_EN
- Defined: err_o is set (sticky until reset) on either protocol violation:
  - in_valid_i dropped, or in_data_i changed, while in_valid_i = 1 and in_ready_o = 0 in the previous cycle;
  - internal invariant breach (SRAM occupancy + slots != count_o).
- Undefined: err_o is tied to 0 and no checking logic is synthesised.

Decomposition:
- Shared package sram_fifo_pkg:
  - count width function cnt_w(depth) = $clog2(depth+1);
  - pointer wrap helper;
  - enum for prefetch slot state (EMPTY, ONE, TWO).
- One natural sub-module, fifo_prefetch_buf: the 2-entry show-ahead buffer with bypass input, SRAM-return input and in-flight tracking.
- The existing sram_dualport macro is instantiated unchanged.

Test Plan:
- Reset, then push 0xA5 once -> out_valid_o = 1 and out_data_o = 0xA5 next cycle; count_o = 1.
- DEPTH=16: push 16 words 0..15 with out_ready_i = 0 -> in_ready_o = 0 after the 16th; almost_full_o high from count 14; a 17th in_valid_i is refused.
- Full FIFO, then out_ready_i = 1 for 16 cycles -> data 0..15 in order, one per cycle, no bubbles; count_o reaches 0; out_valid_o = 0 after.
- DEPTH=5: continuous push and pop for 40 cycles from count 3 -> output is the input delayed in order; count_o stays 3; pointers wrap correctly past 4.
- count 1, simultaneous push 0x3C and pop -> head becomes 0x3C next cycle; count_o = 1.
- Assert rst_i asynchronously mid-burst at count 7 -> outputs reach reset values without a clock edge; first post-reset push behaves as on an empty FIFO.
